// File: rtl/reg_bank_ctrl.sv
// Parametrised DEPTH x DATA_W register bank behind a sel/wr/ready handshake,
// with byte strobes, read-only masking, wait states and an access-error flag.
module reg_bank_ctrl #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 16,
   parameter int                DEPTH     = 16,
   parameter int                WAIT_CYC  = 1,
   parameter logic [DATA_W-1:0] RESET_VAL = 'h1234,
   parameter logic [DEPTH-1:0]  RO_MASK   = '0,
   parameter logic [DATA_W-1:0] ERR_DATA  = 'hDEAD
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                sel,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic                err
);

   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [DATA_W-1:0]   regs [DEPTH];

   logic                l_wr;
   logic [ADDR_W-1:0]   l_addr;
   logic [DATA_W-1:0]   l_wdata;
   logic [NB-1:0]       l_wstrb;

   logic                accept;
   logic                done;
   logic                t_wr;
   logic [ADDR_W-1:0]   t_addr;
   logic [DATA_W-1:0]   t_wdata;
   logic [NB-1:0]       t_wstrb;
   logic [IW-1:0]       t_idx;
   logic                t_inr;
   logic                t_ro;

   // With no wait states the transaction completes on the accept edge,
   // so it is taken straight from the bus instead of the latches.
   always_comb begin
      accept  = sel && ready;
      t_wr    = l_wr;
      t_addr  = l_addr;
      t_wdata = l_wdata;
      t_wstrb = l_wstrb;
      done    = (state == BUSY) && (cnt == 4'd0);
      if (WAIT_CYC == 0) begin
         t_wr    = wr;
         t_addr  = addr;
         t_wdata = wdata;
         t_wstrb = wstrb;
         done    = accept;
      end
      t_idx = t_addr[IW-1:0];
      t_inr = 64'(t_addr) < 64'(DEPTH);
      t_ro  = t_inr && RO_MASK[t_idx];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ready   <= 1'b1;
         err     <= 1'b0;
         rdata   <= '0;
         l_wr    <= 1'b0;
         l_addr  <= '0;
         l_wdata <= '0;
         l_wstrb <= '0;
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= RESET_VAL;
      end else begin
         if (WAIT_CYC != 0) begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     state   <= BUSY;
                     ready   <= 1'b0;
                     cnt     <= CNT_INIT;
                     l_wr    <= wr;
                     l_addr  <= addr;
                     l_wdata <= wdata;
                     l_wstrb <= wstrb;
                  end
               end
               BUSY: begin
                  if (cnt != 4'd0) begin
                     cnt <= cnt - 4'd1;
                  end else begin
                     state <= IDLE;
                     ready <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
         if (done) begin
            if (t_wr) begin
               if (t_inr && !t_ro) begin
                  for (int b = 0; b < NB; b++)
                     if (t_wstrb[b])
                        regs[t_idx][b*8 +: 8] <= t_wdata[b*8 +: 8];
                  err <= 1'b0;
               end else begin
                  err <= 1'b1;
               end
            end else if (t_inr) begin
               rdata <= regs[t_idx];
               err   <= 1'b0;
            end else begin
               rdata <= ERR_DATA;
               err   <= 1'b1;
            end
         end
      end
   end

endmodule
